// File: rtl/vec_elementwise_alu_if.sv
// Stream bundle for vec_elementwise_alu.
// Purpose : carries the input beat channel (valid/ready, operands A and B,
//           op select, last marker) and the output beat channel
//           (valid/ready, result data, last marker, per-lane saturation flags).
// Modports: slave  - the ALU side (consumes the in_* channel, produces out_*)
//           master - the producer/consumer side wrapped around the ALU
interface vec_elementwise_alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH*LANES-1:0]   in_a;
    logic [DATA_WIDTH*LANES-1:0]   in_b;
    logic [1:0]                    in_op;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH*LANES-1:0]   out_data;
    logic                          out_last;
    logic [LANES-1:0]              out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sat
    );
endinterface

// File: rtl/vec_elementwise_alu.sv
// Element-wise saturating fixed-point ALU over LANES signed lanes.
// Purpose : per beat, applies add / sub (A-B) / fixed-point mul / signed max
//           to every lane, saturating add, sub and mul results into the lane
//           range and flagging clamped lanes. LATENCY-deep stall-able pipeline.
// Ports   : clk        - rising-edge clock
//           rst        - synchronous active-high reset
//           bus        - stream bundle (slave modport): in_* beat channel,
//                        out_* result channel
//           beat_count - output beats transferred since reset (wraps)
// Pipeline: stage 1 holds the full-precision raw result of each lane (the
//           multiplier feeds this register); stage 2 scales / saturates it;
//           stages 3..LATENCY are plain delay registers.
module vec_elementwise_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 16,
    parameter int FRAC_BITS  = 16,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_elementwise_alu_if.slave  bus,
    output logic [31:0]           beat_count
);
    localparam int DW = DATA_WIDTH;
    localparam int WW = 2 * DATA_WIDTH;
    localparam int VW = DATA_WIDTH * LANES;
    localparam int NT = LATENCY - 1;   // registers after the raw stage

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    // Lane range expressed at the wide raw width so clamping is one compare.
    localparam logic signed [WW-1:0] SAT_HI = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_LO = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Clamp a wide signed value into the lane range; MSB of result = clamped.
    function automatic logic [DW:0] saturate(input logic signed [WW-1:0] v);
        logic [DW:0] r;
        if (v > SAT_HI) begin
            r = {1'b1, SAT_HI[DW-1:0]};
        end else if (v < SAT_LO) begin
            r = {1'b1, SAT_LO[DW-1:0]};
        end else begin
            r = {1'b0, v[DW-1:0]};
        end
        return r;
    endfunction

    // Full-precision raw lane result; a 2*DW product of DW-bit operands
    // always fits, so nothing is lost before the scaling stage.
    function automatic logic signed [WW-1:0] lane_raw(input logic [1:0]    op,
                                                      input logic [DW-1:0] a,
                                                      input logic [DW-1:0] b);
        logic signed [WW-1:0] aw;
        logic signed [WW-1:0] bw;
        logic signed [WW-1:0] r;
        aw = {{DW{a[DW-1]}}, a};
        bw = {{DW{b[DW-1]}}, b};
        case (op)
            OP_ADD:  r = aw + bw;
            OP_SUB:  r = aw - bw;
            OP_MUL:  r = aw * bw;
            OP_MAX:  r = (aw > bw) ? aw : bw;
            default: r = {WW{1'b0}};
        endcase
        return r;
    endfunction

    // Scale and clamp a raw lane; max is already in range and never clamps.
    function automatic logic [DW:0] lane_finish(input logic [1:0]           op,
                                                input logic signed [WW-1:0] raw);
        logic [DW:0] r;
        case (op)
            OP_MUL:  r = saturate(raw >>> FRAC_BITS);
            OP_MAX:  r = {1'b0, raw[DW-1:0]};
            default: r = saturate(raw);
        endcase
        return r;
    endfunction

    logic                  en_s;
    logic signed [WW-1:0]  raw_q  [LANES];
    logic signed [WW-1:0]  raw_d  [LANES];
    logic [1:0]            op_q, op_d;
    logic                  last0_q, last0_d;
    logic                  vld0_q, vld0_d;
    logic [VW-1:0]         dat_q  [NT];
    logic [VW-1:0]         dat_d  [NT];
    logic [LANES-1:0]      sat_q  [NT];
    logic [LANES-1:0]      sat_d  [NT];
    logic                  last_q [NT];
    logic                  last_d [NT];
    logic                  vld_q  [NT];
    logic                  vld_d  [NT];
    logic [31:0]           beat_count_q, beat_count_d;
    logic [VW-1:0]         fin_dat_s;
    logic [LANES-1:0]      fin_sat_s;

    // The whole pipeline moves together; it only stalls when a result is
    // waiting at the output and the consumer refuses it.
    assign en_s         = !vld_q[NT-1] || bus.out_ready;
    assign bus.in_ready = en_s && !rst;

    assign bus.out_valid = vld_q[NT-1];
    assign bus.out_data  = dat_q[NT-1];
    assign bus.out_last  = last_q[NT-1];
    assign bus.out_sat   = sat_q[NT-1];
    assign beat_count    = beat_count_q;

    // Scale/saturate every lane held in the raw stage.
    always_comb begin
        fin_dat_s = {VW{1'b0}};
        fin_sat_s = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            {fin_sat_s[i], fin_dat_s[i*DW +: DW]} = lane_finish(op_q, raw_q[i]);
        end
    end

    // Next-state for all pipeline registers and the beat counter.
    always_comb begin
        raw_d        = raw_q;
        op_d         = op_q;
        last0_d      = last0_q;
        vld0_d       = vld0_q;
        dat_d        = dat_q;
        sat_d        = sat_q;
        last_d       = last_q;
        vld_d        = vld_q;
        beat_count_d = beat_count_q;
        if (en_s) begin
            for (int i = 0; i < LANES; i++) begin
                raw_d[i] = lane_raw(bus.in_op, bus.in_a[i*DW +: DW], bus.in_b[i*DW +: DW]);
            end
            op_d      = bus.in_op;
            last0_d   = bus.in_last;
            vld0_d    = bus.in_valid;
            dat_d[0]  = fin_dat_s;
            sat_d[0]  = fin_sat_s;
            last_d[0] = last0_q;
            vld_d[0]  = vld0_q;
            for (int s = 1; s < NT; s++) begin
                dat_d[s]  = dat_q[s-1];
                sat_d[s]  = sat_q[s-1];
                last_d[s] = last_q[s-1];
                vld_d[s]  = vld_q[s-1];
            end
        end else begin
            vld_d = vld_q;
        end
        if (vld_q[NT-1] && bus.out_ready) begin
            beat_count_d = beat_count_q + 32'd1;
        end else begin
            beat_count_d = beat_count_q;
        end
    end

    // State registers; reset empties the pipeline and clears all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                raw_q[i] <= {WW{1'b0}};
            end
            op_q    <= 2'b00;
            last0_q <= 1'b0;
            vld0_q  <= 1'b0;
            for (int s = 0; s < NT; s++) begin
                dat_q[s]  <= {VW{1'b0}};
                sat_q[s]  <= {LANES{1'b0}};
                last_q[s] <= 1'b0;
                vld_q[s]  <= 1'b0;
            end
            beat_count_q <= 32'd0;
        end else begin
            raw_q        <= raw_d;
            op_q         <= op_d;
            last0_q      <= last0_d;
            vld0_q       <= vld0_d;
            dat_q        <= dat_d;
            sat_q        <= sat_d;
            last_q       <= last_d;
            vld_q        <= vld_d;
            beat_count_q <= beat_count_d;
        end
    end
endmodule

// File: doc/vec_elementwise_alu.md
VEC_ELEMENTWISE_ALU -- requirements
Module: vec_elementwise_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one signed two's-complement lane.
REQ-002 Parameter LANES, default 16: number of parallel lanes.
REQ-003 Parameter FRAC_BITS, default 16: fractional bits of the fixed-point format; range 0..DATA_WIDTH-1.
REQ-004 Parameter LATENCY, default 3: pipeline depth in cycles; range 2..8.
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_a  input  DATA_WIDTH*LANES  operand A; lane i is bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-010 in_b  input  DATA_WIDTH*LANES  operand B; same lane packing as in_a.
REQ-011 in_op  input  2  operation select: 00 add, 01 sub (A-B), 10 mul, 11 max.
REQ-012 in_last  input  1  end-of-vector marker, carried with the beat.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream accepts a beat.
REQ-015 out_data  output  DATA_WIDTH*LANES  result, same lane packing.
REQ-016 out_last  output  1  in_last of the same beat.
REQ-017 out_sat  output  LANES  per-lane flag: saturation occurred for this beat.
REQ-018 beat_count  output  32  number of output beats transferred since reset; wraps modulo 2^32.

Function
REQ-019 A beat is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-020 Pipeline enable SHALL be en = !out_valid || out_ready, and in_ready SHALL equal en, combinationally.
REQ-021 When en=1, every stage advances one position; when en=0, all stage registers (data, op, last, valid, sat) hold.
REQ-022 An accepted beat SHALL appear at the output exactly LATENCY enabled cycles after acceptance, with no stall in between giving a latency of LATENCY clocks.
REQ-023 Beats leave in acceptance order; none is dropped or duplicated; empty slots (bubbles) propagate as out_valid=0 and are not compressed.
REQ-024 op and last travel with their beat; a change of in_op between beats affects only the beats that carry the new op.
REQ-025 add/sub: full-precision sum/difference, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 mul: full 2*DATA_WIDTH product, arithmetic shift right by FRAC_BITS (truncation toward -inf), then saturated to the same range.
REQ-027 max: signed maximum of A and B; never saturates.
REQ-028 out_sat[i]=1 iff lane i of that beat was clamped.
REQ-029 The multiply SHALL be registered across at least two of the LATENCY stages; the remaining stages are pass-through registers.
REQ-030 beat_count SHALL increment by 1 on each cycle with out_valid && out_ready, and wrap from 2^32-1 to 0.
REQ-031 out_data, out_last and out_sat SHALL be stable while out_valid=1 && out_ready=0.

Reset
REQ-032 While rst=1 at a clock edge: all stage valids are cleared, out_valid=0, beat_count=0, out_data=0, out_last=0, out_sat=0.
REQ-033 in_ready SHALL be 0 while rst=1 and SHALL follow REQ-020 from the first cycle after rst deasserts.
REQ-034 Reset asserted mid-operation discards all in-flight beats; none is delivered after reset deasserts.

Verification (DATA_WIDTH=16, FRAC_BITS=8, LANES=4, LATENCY=3)
REQ-035 Mul, lane0 A=0x0180 (1.5), B=0x0200 (2.0), out_ready=1 -> 3 cycles later lane0=0x0300, out_sat[0]=0, beat_count=1.
REQ-036 Add, A=0x7F00, B=0x0200 -> lane=0x7FFF, out_sat=1; sub A=0x8000, B=0x0001 -> 0x8000, out_sat=1; max A=0xFF00, B=0x0010 -> 0x0010.
REQ-037 Stream 10 back-to-back beats with mixed ops, out_ready low for cycles 4-7 -> in_ready low in the same cycles, held output stable, all 10 results in order, out_last on beat 10 only, beat_count=10.
REQ-038 Accept 2 beats, assert rst for 1 cycle with 2 beats in flight -> no out_valid afterwards; beat_count=0; a new beat returns after 3 cycles.
REQ-039 Inputs with in_valid toggling 1,0,1 -> outputs with out_valid 1,0,1 at the same spacing, 3 cycles later.
REQ-040 Preload beat_count to 0xFFFFFFFF (via 2^32-1 transfers or forced state) and deliver 1 beat -> beat_count=0.
